apb_mem_arbiter: RTL and testbench

- APB master that shares a single 128-entry APB memory slave between NREQ local requesters.
- Accepts simple valid/ready requests and arbitrates round-robin.
- Sequences the APB SETUP/ACCESS phases and returns read data and error status to the owning requester.
- Adds local address-range rejection and an access-phase timeout, so a hung or absent slave cannot lock the bus.

---
 rtl/apb_mem_pkg.sv | 19 +
 rtl/apb_mem_arbiter_rr_arbiter.sv | 27 ++
 rtl/apb_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_apb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and defaults for the APB memory arbiter.
package apb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MEM_DEPTH = 128;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int tmo_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_mem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             adv,
    output logic [NREQ-1:0]  gnt
);

    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (adv && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// APB master sharing one memory slave between NREQ requesters, with
// local address-range rejection and an ACCESS-phase timeout.
module apb_mem_arbiter
    import apb_mem_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int TIMEOUT   = 16
) (
    input  logic                     pclk,
    input  logic                     prst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic [ADDR_W-1:0]        paddr,
    output logic                     pwrite,
    output logic [DATA_W-1:0]        pwdata,
    output logic                     psel,
    output logic                     penable,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    input  logic                     pslverr
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int TMO_W = tmo_width(TIMEOUT);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    owner;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_nxt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_write;
    logic               idle;
    logic               hs;
    logic               in_range;

    assign idle      = (state == IDLE);
    assign busy      = !idle;
    assign req_ready = gnt;
    assign hs        = |gnt;
    assign tmo_nxt   = tmo_cnt + TMO_W'(1);
    assign in_range  = 32'(sel_addr) < MEM_DEPTH;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .adv (idle),
        .gnt (gnt)
    );

    // Pick out the winner's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
                gnt_idx   = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state       <= IDLE;
            ptr         <= PTR_W'(NREQ - 1);
            owner       <= '0;
            tmo_cnt     <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        owner <= gnt;
                        ptr   <= gnt_idx;
                        if (in_range) begin
                            paddr  <= sel_addr;
                            pwdata <= sel_wdata;
                            pwrite <= sel_write;
                            psel   <= 1'b1;
                            state  <= SETUP;
                        end else begin
                            // Rejected locally; the bus is never touched.
                            rsp_valid   <= gnt;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= owner;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        state       <= IDLE;
                    end else if (tmo_nxt == TMO_W'(TIMEOUT)) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= owner;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Self-checking bench for apb_mem_arbiter: APB memory slave model, scoreboard
// of expected responses, vector table plus fairness and reset sequences.
module tb_apb_mem_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int AW_T   = NREQ * ADDR_W;
    localparam int DW_T   = NREQ * DATA_W;

    logic              pclk = 1'b0;
    logic              prst;
    logic [NREQ-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [AW_T-1:0]   req_addr;
    logic [DW_T-1:0]   req_wdata;
    logic [DATA_W-1:0] rsp_rdata, pwdata, prdata;
    logic              rsp_err, rsp_timeout, busy, pwrite, psel, penable, pready, pslverr;
    logic [ADDR_W-1:0] paddr;

    apb_mem_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(128), .TIMEOUT(16)
    ) dut (
        .pclk(pclk), .prst(prst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Memory slave: pready on the second ACCESS cycle unless hung.
    logic [7:0] mem [0:127];
    bit         mem_ready;
    int         acc_cnt;
    bit         hang_mode, err_mode;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 7 + 19);
    endfunction

    assign pready  = psel && penable && !hang_mode && (acc_cnt == 1);
    assign pslverr = err_mode;
    assign prdata  = mem[paddr[6:0]];

    always @(posedge pclk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (psel && penable && pready && pwrite && !err_mode) begin
            mem[paddr[6:0]] <= pwdata;
        end
        acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
    end

    typedef struct packed {
        logic [NREQ-1:0] owner;
        logic [7:0]      rdata;
        logic            err;
        logic            tmo;
    } rsp_t;

    typedef struct {
        int         rq;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         serr;
        bit         hang;
        logic [7:0] e_rdata;
        bit         e_err;
        bit         e_tmo;
        int         e_lat;
        int         e_pen;
    } vec_t;

    rsp_t sb[$];
    rsp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Response monitor and protocol checks.
    bit psel_q, pen_q;
    always @(negedge pclk) begin
        if (prst) begin
            psel_q = 1'b0;
            pen_q  = 1'b0;
        end else begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_owner", 32'(rsp_valid), 32'(mon_e.owner));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
                end
            end
            if (penable && !pen_q) check("setup_before_access", {psel_q, pen_q}, 2'b10);
            if (busy && req_valid != '0) check("ready_low_busy", 32'(req_ready), 32'd0);
            psel_q = psel;
            pen_q  = penable;
        end
    end

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge pclk);
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic do_req(input vec_t v, input int idx);
        int   lat, pen, k;
        bit   saw_psel;
        rsp_t e;
        err_mode = v.serr;
        hang_mode = v.hang;
        @(negedge pclk);
        req_valid = '0;
        req_valid[v.rq] = 1'b1;
        req_write[v.rq] = v.wr;
        req_addr[v.rq*ADDR_W +: ADDR_W] = v.addr;
        req_wdata[v.rq*DATA_W +: DATA_W] = v.wdata;
        #1;
        k = 0;
        while (!req_ready[v.rq] && k < 50) begin
            @(negedge pclk); #1;
            k++;
        end
        check($sformatf("grant[%0d]", idx), 32'(req_ready), 32'(1 << v.rq));
        e.owner = NREQ'(1 << v.rq);
        e.rdata = v.e_rdata;
        e.err   = v.e_err;
        e.tmo   = v.e_tmo;
        if (req_ready[v.rq]) sb.push_back(e);
        @(posedge pclk); #1;
        req_valid = '0;
        req_addr  = AW_T'($urandom);
        req_wdata = DW_T'($urandom);
        req_write = NREQ'($urandom);
        lat = 0; pen = 0; saw_psel = 1'b0;
        while (lat < 40) begin
            @(negedge pclk);
            lat++;
            if (psel) saw_psel = 1'b1;
            if (psel && penable) pen++;
            if (rsp_valid != '0) break;
        end
        check($sformatf("latency[%0d]", idx), lat, v.e_lat);
        check($sformatf("access_cycles[%0d]", idx), pen, v.e_pen);
        check($sformatf("psel_seen[%0d]", idx), 32'(saw_psel), 32'(v.e_lat != 1));
        check($sformatf("bus_idle_at_rsp[%0d]", idx), {psel, penable}, 2'b00);
        @(negedge pclk);
        check($sformatf("rsp_pulse[%0d]", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("rsp_hold[%0d]", idx), {rsp_rdata, rsp_err, rsp_timeout}, {v.e_rdata, v.e_err, v.e_tmo});
    endtask

    task automatic fair_test();
        int   n0, n1, exp_g, cyc, g;
        rsp_t e;
        n0 = 0; n1 = 0; exp_g = 0; cyc = 0;
        err_mode = 1'b0;
        hang_mode = 1'b0;
        @(negedge pclk);
        req_write = '0;
        req_addr  = {8'd40, 8'd20};
        req_valid = 2'b11;
        while ((n0 < 4 || n1 < 4) && cyc < 200) begin
            #1;
            if ((req_ready & req_valid) != '0) begin
                g = req_ready[1] ? 1 : 0;
                check("fair_grant", g, exp_g);
                exp_g = 1 - g;
                e.owner = NREQ'(1 << g);
                e.rdata = init_val(int'(req_addr[g*ADDR_W +: ADDR_W]));
                e.err = 1'b0;
                e.tmo = 1'b0;
                sb.push_back(e);
                @(posedge pclk); #1;
                if (g == 0) n0++; else n1++;
                if ((g == 0 ? n0 : n1) >= 4) req_valid[g] = 1'b0;
                else req_addr[g*ADDR_W +: ADDR_W] = req_addr[g*ADDR_W +: ADDR_W] + 8'd1;
            end
            @(negedge pclk);
            cyc++;
        end
        check("fair_count0", n0, 4);
        check("fair_count1", n1, 4);
        req_valid = '0;
        wait_drain("fair_drain");
    endtask

    task automatic reset_test();
        int   k;
        rsp_t e;
        hang_mode = 1'b1;
        err_mode = 1'b0;
        @(negedge pclk);
        req_write = '0;
        req_addr[7:0] = 8'd3;
        req_valid = 2'b01;
        #1;
        check("rst_pre_grant", 32'(req_ready), 32'b01);
        @(posedge pclk); #1;
        req_valid = '0;
        k = 0;
        while (!penable && k < 10) begin
            @(negedge pclk);
            k++;
        end
        check("rst_in_access", 32'(penable), 32'd1);
        @(posedge pclk); #2;
        prst = 1'b1;
        #1;
        check("rst_async_apb", {psel, penable}, 2'b00);
        check("rst_async_busy", 32'(busy), 32'd0);
        @(negedge pclk);
        check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        hang_mode = 1'b0;
        @(posedge pclk); #1;
        prst = 1'b0;
        @(negedge pclk);
        req_addr  = {8'd41, 8'd21};
        req_valid = 2'b11;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'b01);
        e.owner = 2'b01; e.rdata = init_val(21); e.err = 1'b0; e.tmo = 1'b0;
        if (req_ready[0]) sb.push_back(e);
        @(posedge pclk); #1;
        req_valid = 2'b10;
        k = 0;
        while (!req_ready[1] && k < 20) begin
            @(negedge pclk); #1;
            k++;
        end
        check("rst_second_grant", 32'(req_ready), 32'b10);
        e.owner = 2'b10; e.rdata = init_val(41);
        if (req_ready[1]) sb.push_back(e);
        @(posedge pclk); #1;
        req_valid = '0;
        wait_drain("rst_drain");
    endtask

    vec_t tv[12];

    initial begin
        tv[0]  = '{0, 1'b1, 8'd5,   8'hA5, 1'b0, 1'b0, 8'h00,        1'b0, 1'b0, 4, 2};
        tv[1]  = '{0, 1'b0, 8'd5,   8'h00, 1'b0, 1'b0, 8'hA5,        1'b0, 1'b0, 4, 2};
        tv[2]  = '{1, 1'b0, 8'd200, 8'h00, 1'b0, 1'b0, 8'h00,        1'b1, 1'b0, 1, 0};
        tv[3]  = '{0, 1'b0, 8'd9,   8'h00, 1'b0, 1'b1, 8'h00,        1'b1, 1'b1, 18, 16};
        tv[4]  = '{1, 1'b0, 8'd5,   8'h00, 1'b0, 1'b0, 8'hA5,        1'b0, 1'b0, 4, 2};
        tv[5]  = '{1, 1'b1, 8'd9,   8'h5A, 1'b1, 1'b0, 8'h00,        1'b1, 1'b0, 4, 2};
        tv[6]  = '{0, 1'b0, 8'd9,   8'h00, 1'b0, 1'b0, init_val(9),  1'b0, 1'b0, 4, 2};
        tv[7]  = '{0, 1'b1, 8'd127, 8'h3C, 1'b0, 1'b0, 8'h00,        1'b0, 1'b0, 4, 2};
        tv[8]  = '{1, 1'b0, 8'd127, 8'h00, 1'b0, 1'b0, 8'h3C,        1'b0, 1'b0, 4, 2};
        tv[9]  = '{0, 1'b1, 8'd128, 8'h77, 1'b0, 1'b0, 8'h00,        1'b1, 1'b0, 1, 0};
        tv[10] = '{1, 1'b0, 8'd255, 8'h00, 1'b0, 1'b0, 8'h00,        1'b1, 1'b0, 1, 0};
        tv[11] = '{1, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, init_val(0),  1'b0, 1'b0, 4, 2};

        prst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        hang_mode = 1'b0; err_mode = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 32'd0);
        check("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge pclk); #1;
        prst = 1'b0;

        fair_test();
        for (int i = 0; i < 12; i++) do_req(tv[i], i);
        reset_test();

        repeat (2) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
